// File: rtl/bullet_pool.sv
// Pool of independent projectiles: each slot latches its direction at spawn,
// moves SPEED pixels per frame and despawns when it would cross the playfield edge.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 2,
  parameter int COOLDOWN    = 8,
  parameter int BULLET_SIZE = 3,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      shoot,
  input  logic [1:0]                Direction,
  input  logic [9:0]                ShooterX,
  input  logic [9:0]                ShooterY,
  output logic [NUM_BULLETS*10-1:0] BulletX,
  output logic [NUM_BULLETS*10-1:0] BulletY,
  output logic [NUM_BULLETS-1:0]    BulletActive,
  output logic                      fire_ack,
  output logic                      pool_full
);

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  localparam logic signed [11:0] SPEED_S = 12'(SPEED);
  localparam logic signed [11:0] SIZE_S  = 12'(BULLET_SIZE);
  localparam logic signed [11:0] XMIN_S  = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
  localparam logic signed [11:0] YMIN_S  = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S  = 12'(Y_MAX);

  logic [9:0]             x_q [NUM_BULLETS];
  logic [9:0]             x_d [NUM_BULLETS];
  logic [9:0]             y_q [NUM_BULLETS];
  logic [9:0]             y_d [NUM_BULLETS];
  logic [1:0]             dir_q [NUM_BULLETS];
  logic [1:0]             dir_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic [CW-1:0]          cd_q, cd_d;
  logic                   fire_ack_q, fire_ack_d;

  logic                   spawn_ok, found;
  logic signed [11:0]     cand;
  logic                   horiz, out_of_bounds;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    dir_d         = dir_q;
    active_d      = active_q;
    found         = 1'b0;
    cand          = '0;
    horiz         = 1'b0;
    out_of_bounds = 1'b0;
    spawn_ok      = shoot && (cd_q == '0);

    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (active_q[i]) begin
        horiz = (dir_q[i] == DIR_LEFT) || (dir_q[i] == DIR_RIGHT);
        case (dir_q[i])
          DIR_LEFT:  cand = $signed({2'b00, x_q[i]}) - SPEED_S;
          DIR_RIGHT: cand = $signed({2'b00, x_q[i]}) + SPEED_S;
          DIR_DOWN:  cand = $signed({2'b00, y_q[i]}) + SPEED_S;
          default:   cand = $signed({2'b00, y_q[i]}) - SPEED_S;
        endcase
        if (horiz)
          out_of_bounds = (cand - SIZE_S < XMIN_S) || (cand + SIZE_S > XMAX_S);
        else
          out_of_bounds = (cand - SIZE_S < YMIN_S) || (cand + SIZE_S > YMAX_S);
        if (out_of_bounds)
          active_d[i] = 1'b0;
        else if (horiz)
          x_d[i] = cand[9:0];
        else
          y_d[i] = cand[9:0];
      end else if (!found) begin
        // Eligibility uses the pre-edge mask, so a slot freed this edge waits a frame.
        found = 1'b1;
        if (spawn_ok) begin
          x_d[i]      = ShooterX;
          y_d[i]      = ShooterY;
          dir_d[i]    = Direction;
          active_d[i] = 1'b1;
        end
      end
    end

    fire_ack_d = spawn_ok && found;
    if (fire_ack_d)
      cd_d = CW'(COOLDOWN);
    else if (cd_q != '0)
      cd_d = cd_q - CW'(1);
    else
      cd_d = cd_q;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        dir_q[i] <= DIR_LEFT;
      end
      active_q   <= '0;
      cd_q       <= '0;
      fire_ack_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      active_q   <= active_d;
      cd_q       <= cd_d;
      fire_ack_q <= fire_ack_d;
    end
  end

  always_comb begin
    BulletX = '0;
    BulletY = '0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      BulletX[i*10 +: 10] = x_q[i];
      BulletY[i*10 +: 10] = y_q[i];
    end
  end

  assign BulletActive = active_q;
  assign fire_ack     = fire_ack_q;
  assign pool_full    = &active_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: a vector table for single-shot and latched
// direction, plus hand sequences for cooldown, pool full, despawn and async reset.
module tb_bullet_pool;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic        shoot     = 1'b0;
  logic        shoot0    = 1'b0;
  logic [1:0]  Direction = 2'b00;
  logic [9:0]  ShooterX  = '0;
  logic [9:0]  ShooterY  = '0;

  logic [39:0] BulletX, BulletY, BulletX0, BulletY0;
  logic [3:0]  BulletActive, BulletActive0;
  logic        fire_ack, pool_full, fire_ack0, pool_full0;

  int n_vec = 0;
  int n_err = 0;

  always #5 frame_clk = ~frame_clk;

  bullet_pool #(.NUM_BULLETS(4), .SPEED(2), .COOLDOWN(8), .BULLET_SIZE(3)) u_dut (
    .frame_clk(frame_clk), .Reset(Reset), .shoot(shoot), .Direction(Direction),
    .ShooterX(ShooterX), .ShooterY(ShooterY), .BulletX(BulletX), .BulletY(BulletY),
    .BulletActive(BulletActive), .fire_ack(fire_ack), .pool_full(pool_full)
  );

  bullet_pool #(.NUM_BULLETS(4), .SPEED(2), .COOLDOWN(0), .BULLET_SIZE(3)) u_dut0 (
    .frame_clk(frame_clk), .Reset(Reset), .shoot(shoot0), .Direction(Direction),
    .ShooterX(ShooterX), .ShooterY(ShooterY), .BulletX(BulletX0), .BulletY(BulletY0),
    .BulletActive(BulletActive0), .fire_ack(fire_ack0), .pool_full(pool_full0)
  );

  typedef struct {
    logic       rst;
    logic       sh;
    logic [1:0] dir;
    int         sx, sy;
    int         slot;
    logic       ack;
    logic [3:0] act;
    int         ex, ey;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic rst, logic sh, logic [1:0] dir, int sx, int sy,
                              int slot, logic ack, logic [3:0] act, int ex, int ey);
    vec_t v;
    v.rst = rst; v.sh = sh; v.dir = dir; v.sx = sx; v.sy = sy;
    v.slot = slot; v.ack = ack; v.act = act; v.ex = ex; v.ey = ey;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    // Single shot: slot0 spawns at (100,200) moving right
    vecs[0] = mk(1, 1, 2'b01, 100, 200, 0, 1, 4'b0001, 100, 200);
    for (int e = 1; e <= 5; e++)
      vecs[e] = mk(0, 0, 2'b01, 100, 200, 0, 0, 4'b0001, 100 + 2*e, 200);
    // Latched direction: slot0 fired upward, Direction changes while shoot held in cooldown
    vecs[6] = mk(1, 1, 2'b11, 300, 300, 0, 1, 4'b0001, 300, 300);
    for (int e = 1; e <= 8; e++)
      vecs[6+e] = mk(0, 1, 2'b00, 320, 240, 0, 0, 4'b0001, 300, 300 - 2*e);
    vecs[15] = mk(0, 1, 2'b00, 320, 240, 1, 1, 4'b0011, 320, 240);
    vecs[16] = mk(0, 0, 2'b00, 320, 240, 1, 0, 4'b0011, 318, 240);
    vecs[17] = mk(0, 0, 2'b00, 320, 240, 0, 0, 4'b0011, 300, 278);

    // Reset state, asserted from time 0 before any clock edge
    #2;
    chk("reset_active", BulletActive, 0);
    chk("reset_x", BulletX[31:0], 0);
    chk("reset_ack", fire_ack, 0);
    chk("reset_full", pool_full, 0);
    Reset = 1'b0;

    foreach (vecs[k]) begin
      if (vecs[k].rst) pulse_reset();
      shoot = vecs[k].sh; Direction = vecs[k].dir;
      ShooterX = 10'(vecs[k].sx); ShooterY = 10'(vecs[k].sy);
      step();
      chk($sformatf("vec%0d_ack", k), fire_ack, vecs[k].ack);
      chk($sformatf("vec%0d_act", k), BulletActive, vecs[k].act);
      chk($sformatf("vec%0d_x", k), BulletX[vecs[k].slot*10 +: 10], vecs[k].ex);
      chk($sformatf("vec%0d_y", k), BulletY[vecs[k].slot*10 +: 10], vecs[k].ey);
    end
    shoot = 1'b0;

    // Cooldown: held shoot fires on edges 0, 9, 18
    pulse_reset();
    shoot = 1'b1; Direction = 2'b10; ShooterX = 10'd100; ShooterY = 10'd100;
    for (int e = 0; e <= 18; e++) begin
      step();
      chk($sformatf("cd_ack_e%0d", e), fire_ack, (e == 0 || e == 9 || e == 18) ? 1 : 0);
      chk($sformatf("cd_act_e%0d", e), BulletActive, (e < 9) ? 1 : (e < 18) ? 3 : 7);
      chk($sformatf("cd_y0_e%0d", e), BulletY[9:0], 100 + 2*e);
    end
    shoot = 1'b0;

    // Pool full on the zero-cooldown instance
    pulse_reset();
    shoot0 = 1'b1; Direction = 2'b01; ShooterX = 10'd320; ShooterY = 10'd240;
    for (int e = 0; e <= 3; e++) begin
      step();
      chk($sformatf("pf_ack_e%0d", e), fire_ack0, 1);
      chk($sformatf("pf_act_e%0d", e), BulletActive0, (1 << (e + 1)) - 1);
      chk($sformatf("pf_full_e%0d", e), pool_full0, (e == 3) ? 1 : 0);
    end
    step();
    chk("pf_ack_e4", fire_ack0, 0);
    chk("pf_full_e4", pool_full0, 1);
    chk("pf_x0_e4", BulletX0[9:0], 328);
    shoot0 = 1'b0;

    // Despawn at the left edge, then reuse of slot 0
    pulse_reset();
    shoot = 1'b1; Direction = 2'b00; ShooterX = 10'd10; ShooterY = 10'd100;
    step();
    chk("ds_spawn_x", BulletX[9:0], 10);
    shoot = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("ds_x_e%0d", e), BulletX[9:0], 10 - 2*e);
      chk($sformatf("ds_act_e%0d", e), BulletActive, 1);
    end
    step();
    chk("ds_act_drop", BulletActive, 0);
    chk("ds_x_hold", BulletX[9:0], 4);
    shoot = 1'b1; Direction = 2'b01; ShooterX = 10'd50;
    for (int e = 5; e <= 8; e++) begin
      step();
      chk($sformatf("ds_cd_ack_e%0d", e), fire_ack, 0);
    end
    step();
    chk("ds_reuse_ack", fire_ack, 1);
    chk("ds_reuse_act", BulletActive, 1);
    chk("ds_reuse_x", BulletX[9:0], 50);
    shoot = 1'b0;

    // Async reset mid-flight with three bullets active
    pulse_reset();
    shoot0 = 1'b1; Direction = 2'b10; ShooterX = 10'd200; ShooterY = 10'd200;
    repeat (3) step();
    chk("ar_pre_act", BulletActive0, 7);
    shoot0 = 1'b0;
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    chk("ar_act", BulletActive0, 0);
    chk("ar_x", BulletX0[29:0], 0);
    chk("ar_y", BulletY0[29:0], 0);
    chk("ar_ack", fire_ack0, 0);
    Reset = 1'b0;
    step();
    chk("ar_idle_act", BulletActive0, 0);
    chk("ar_idle_ack", fire_ack0, 0);
    shoot0 = 1'b1;
    step();
    chk("ar_shot_ack", fire_ack0, 1);
    chk("ar_shot_act", BulletActive0, 1);
    chk("ar_shot_y", BulletY0[9:0], 200);
    shoot0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
